// File: rtl/bpsk_segment_demod_if.sv
// Sample-in / bit-out bundle of the BPSK segment demodulator, including the
// external reference lookup (ref_idx out, ref_sample back in the same cycle).
interface bpsk_segment_demod_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SEGMENTS = 8,
    parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(SEGMENTS) + 1
);
    localparam int unsigned IdxW = $clog2(SEGMENTS);

    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     sym_start;
    logic [IdxW-1:0]          ref_idx;
    logic signed [DATA_W-1:0] ref_sample;
    logic                     bit_out;
    logic [ACC_W-1:0]         metric;
    logic                     bit_valid;
    logic                     bit_ready;
    logic                     resync_err;

    modport master (
        output sample_in, sample_valid, sym_start, ref_sample, bit_ready,
        input  sample_ready, ref_idx, bit_out, metric, bit_valid, resync_err
    );

    modport slave (
        input  sample_in, sample_valid, sym_start, ref_sample, bit_ready,
        output sample_ready, ref_idx, bit_out, metric, bit_valid, resync_err
    );
endinterface

// File: rtl/bpsk_segment_demod.sv
// Per-symbol BPSK correlator: multiply each sample by its reference, accumulate
// over SEGMENTS samples, then emit the sign as the bit and |sum| as the metric.
module bpsk_segment_demod #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SEGMENTS = 8,
    parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(SEGMENTS) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    bpsk_segment_demod_if.slave    dm_io
);
    localparam int unsigned IdxW  = $clog2(SEGMENTS);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SEGMENTS - 1);

    logic                    accept;
    logic                    ready;
    logic [IdxW-1:0]         cur_idx;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic signed [ProdW-1:0] prod_q, prod_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_first_q, s1_first_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    s2_done_q, s2_done_d;
    logic                    bit_out_q, bit_out_d;
    logic [ACC_W-1:0]        metric_q, metric_d;
    logic                    bit_valid_q, bit_valid_d;
    logic                    resync_q, resync_d;

    always_comb begin
        ready   = !(bit_valid_q && !dm_io.bit_ready);
        accept  = dm_io.sample_valid && ready;
        // A flagged sample is segment 0 even before the index register catches up,
        // so the external lookup already returns the first reference value.
        cur_idx = (dm_io.sample_valid && dm_io.sym_start) ? '0 : idx_q;

        idx_d      = idx_q;
        prod_d     = prod_q;
        s1_valid_d = accept;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        resync_d   = resync_q;
        if (accept) begin
            idx_d      = (cur_idx == LastIdx) ? '0 : cur_idx + IdxW'(1);
            prod_d     = ProdW'(dm_io.sample_in) * ProdW'(dm_io.ref_sample);
            s1_first_d = (cur_idx == '0);
            s1_last_d  = (cur_idx == LastIdx);
            if (dm_io.sym_start && idx_q != '0) begin
                resync_d = 1'b1;
            end
        end

        acc_d = acc_q;
        if (s1_valid_q) begin
            acc_d = (s1_first_q ? '0 : acc_q) + ACC_W'(prod_q);
        end
        s2_done_d = s1_valid_q && s1_last_q;

        bit_out_d   = bit_out_q;
        metric_d    = metric_q;
        bit_valid_d = bit_valid_q;
        if (s2_done_q) begin
            bit_out_d   = acc_q[ACC_W-1];
            metric_d    = acc_q[ACC_W-1] ? $unsigned(-acc_q) : $unsigned(acc_q);
            bit_valid_d = 1'b1;
        end else if (dm_io.bit_ready) begin
            bit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q       <= '0;
            prod_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            s2_done_q   <= 1'b0;
            bit_out_q   <= 1'b0;
            metric_q    <= '0;
            bit_valid_q <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            s2_done_q   <= s2_done_d;
            bit_out_q   <= bit_out_d;
            metric_q    <= metric_d;
            bit_valid_q <= bit_valid_d;
            resync_q    <= resync_d;
        end
    end

    assign dm_io.sample_ready = ready;
    assign dm_io.ref_idx      = cur_idx;
    assign dm_io.bit_out      = bit_out_q;
    assign dm_io.metric       = metric_q;
    assign dm_io.bit_valid    = bit_valid_q;
    assign dm_io.resync_err   = resync_q;
endmodule

// File: tb/tb_bpsk_segment_demod.sv
// Directed bench for bpsk_segment_demod: a symbol-level correlation model predicts
// each decided bit, and a compare process checks every output handshake against it.
module tb_bpsk_segment_demod;
    localparam int DW  = 32;
    localparam int SEG = 8;
    localparam int AW  = 2 * DW + $clog2(SEG) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bpsk_segment_demod_if #(.DATA_W(DW), .SEGMENTS(SEG), .ACC_W(AW)) bus ();

    bpsk_segment_demod #(.DATA_W(DW), .SEGMENTS(SEG), .ACC_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .dm_io (bus)
    );

    logic signed [DW-1:0] ref_tab [SEG];
    assign bus.ref_sample = ref_tab[bus.ref_idx];

    typedef struct packed {
        logic          b;
        logic [AW-1:0] m;
    } dec_t;

    dec_t          exp_q [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            ecnt = 0;
    int            hs_cnt = 0;
    int            hs_edge [$];
    logic          last_bit = 1'b0;
    logic [AW-1:0] last_metric = '0;
    logic          held = 1'b0;
    logic          h_bit = 1'b0;
    logic [AW-1:0] h_metric = '0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Symbol-level model: bit is the sign of sum(sample*ref), metric its magnitude.
    function automatic logic signed [AW-1:0] corr(input logic signed [DW-1:0] s [SEG]);
        logic signed [AW-1:0] acc, a, r;
        acc = '0;
        for (int i = 0; i < SEG; i++) begin
            a = AW'(s[i]);
            r = AW'(ref_tab[i]);
            acc += a * r;
        end
        return acc;
    endfunction

    task automatic push_expect(input logic signed [DW-1:0] s [SEG]);
        logic signed [AW-1:0] c;
        dec_t d;
        c = corr(s);
        d.b = (c < 0);
        d.m = (c < 0) ? AW'(-c) : AW'(c);
        exp_q.push_back(d);
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic drive_sample(input logic signed [DW-1:0] s, input logic st);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
        bus.sym_start    = st;
        #1;
        while (!bus.sample_ready) begin
            guard++;
            if (guard > 200) begin
                miscompares++;
                $display("FAIL accept_timeout: sample_ready stuck at %0d, expected 1", bus.sample_ready);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $fatal(1, "stalled");
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
    endtask

    task automatic send_sym(input logic signed [DW-1:0] s [SEG], input logic st);
        for (int i = 0; i < SEG; i++) drive_sample(s[i], st && (i == 0));
        push_expect(s);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sym_start    = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int g;
        g = 0;
        while (hs_cnt < n && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        #3;
        check("hs_count", AW'(hs_cnt), AW'(n));
    endtask

    // Compare process: samples after the negedge drives have settled.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            held = 1'b0;
        end else if (bus.bit_valid) begin
            if (held) begin
                check("hold_bit", AW'(bus.bit_out), AW'(h_bit));
                check("hold_metric", bus.metric, h_metric);
            end
            if (bus.bit_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", AW'(bus.bit_valid), '0);
                end else begin
                    dec_t e;
                    e = exp_q.pop_front();
                    check("bit_out", AW'(bus.bit_out), AW'(e.b));
                    check("metric", bus.metric, e.m);
                end
                last_bit    = bus.bit_out;
                last_metric = bus.metric;
                hs_cnt++;
                hs_edge.push_back(ecnt);
                held = 1'b0;
            end else begin
                held     = 1'b1;
                h_bit    = bus.bit_out;
                h_metric = bus.metric;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        finish_now();
    end

    initial begin
        logic signed [DW-1:0] r   [SEG];
        logic signed [DW-1:0] s   [SEG];
        logic signed [DW-1:0] neg [SEG];
        logic signed [DW-1:0] z   [SEG];
        logic [AW-1:0]        two65;
        int                   base;

        r = '{100, -100, 50, -50, 200, -200, 10, -10};
        for (int i = 0; i < SEG; i++) begin
            neg[i] = -r[i];
            z[i]   = '0;
        end
        ref_tab = r;
        two65 = '0;
        two65[65] = 1'b1;

        bus.sample_in    = 32'sd123;
        bus.sample_valid = 1'b1;
        bus.sym_start    = 1'b0;
        bus.bit_ready    = 1'b1;

        // Reset held with valid samples offered.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_bit_valid", AW'(bus.bit_valid), '0);
        check("rst_bit_out", AW'(bus.bit_out), '0);
        check("rst_metric", bus.metric, '0);
        check("rst_ref_idx", AW'(bus.ref_idx), '0);
        check("rst_resync", AW'(bus.resync_err), '0);
        bus.sample_valid = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("rst_no_bit", AW'(hs_cnt), '0);

        // Bit 0 with latency pinned: visible after the second edge past the last accept.
        send_sym(r, 1'b1);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #1;
        check("lat_e0", AW'(bus.bit_valid), '0);
        @(negedge clk);
        #1;
        check("lat_e1", AW'(bus.bit_valid), '0);
        @(negedge clk);
        #1;
        check("lat_e2", AW'(bus.bit_valid), AW'(1));
        wait_hs(1);
        check("lit_bit0_bit", AW'(last_bit), '0);
        check("lit_bit0_metric", last_metric, AW'(105200));  // 2*(100^2+50^2+200^2+10^2)

        send_sym(neg, 1'b1);
        idle();
        wait_hs(2);
        check("lit_bit1_bit", AW'(last_bit), AW'(1));
        check("lit_bit1_metric", last_metric, AW'(105200));

        // Four back-to-back symbols, alternating bits, no gaps.
        base = hs_edge.size();
        send_sym(r, 1'b1);
        send_sym(neg, 1'b0);
        send_sym(r, 1'b0);
        send_sym(neg, 1'b0);
        idle();
        wait_hs(6);
        for (int k = 1; k < 4; k++) begin
            check("interval", AW'(hs_edge[base + k] - hs_edge[base + k - 1]), AW'(8));
        end

        // Backpressure: first decision held, next symbol stalls then resumes.
        s = '{3, -7, 11, 0, -2, 5, 9, -4};
        bus.bit_ready = 1'b0;
        fork
            begin
                send_sym(s, 1'b1);
                send_sym(neg, 1'b0);
                idle();
            end
            begin
                int g;
                g = 0;
                @(negedge clk);
                #1;
                while (!bus.bit_valid && g < 100) begin
                    @(negedge clk);
                    #1;
                    g++;
                end
                check("stall_ready", AW'(bus.sample_ready), '0);
                repeat (4) @(negedge clk);
                bus.bit_ready = 1'b1;
                @(negedge clk);
                #1;
                check("post_hs_valid", AW'(bus.bit_valid), '0);
                check("post_hs_ready", AW'(bus.sample_ready), AW'(1));
            end
        join
        wait_hs(8);

        // Resync: restart at segment 5, partial symbol is dropped.
        @(negedge clk);
        #1;
        check("pre_resync", AW'(bus.resync_err), '0);
        for (int i = 0; i < 5; i++) drive_sample(r[i], i == 0);
        send_sym(neg, 1'b1);
        idle();
        wait_hs(9);
        check("resync_err", AW'(bus.resync_err), AW'(1));
        check("resync_bit", AW'(last_bit), AW'(1));

        // Tie: zero correlation decides bit 0.
        send_sym(z, 1'b0);
        idle();
        wait_hs(10);
        check("lit_tie_bit", AW'(last_bit), '0);
        check("lit_tie_metric", last_metric, '0);

        // Extremes: most-negative samples and references.
        for (int i = 0; i < SEG; i++) begin
            ref_tab[i] = 32'sh8000_0000;
            s[i]       = 32'sh8000_0000;
        end
        send_sym(s, 1'b0);
        idle();
        wait_hs(11);
        check("lit_ext_bit", AW'(last_bit), '0);
        check("lit_ext_metric", last_metric, two65);
        for (int i = 0; i < SEG; i++) s[i] = 32'sh7fff_ffff;
        send_sym(s, 1'b0);
        idle();
        wait_hs(12);

        // Reset mid-symbol aborts it and clears the sticky error.
        ref_tab = r;
        for (int i = 0; i < 3; i++) drive_sample(neg[i], i == 0);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst2_resync", AW'(bus.resync_err), '0);
        check("rst2_ref_idx", AW'(bus.ref_idx), '0);
        reset = 1'b1;
        s = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_sym(s, 1'b0);
        idle();
        wait_hs(13);

        check("queue_drained", AW'(exp_q.size()), '0);
        finish_now();
    end
endmodule
